// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package mc_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned CMD_W   = 4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_UNKNOWN
  } statetype;

  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_MEM = 2'b01;
  localparam logic [OP_W-1:0] OP_BR  = 2'b10;
  localparam logic [OP_W-1:0] OP_UND = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;

  // Ungated per-state controls produced by the sequencing FSM.
  typedef struct packed {
    logic       pc_update;
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       alu_op;
  } raw_ctrl_t;

endpackage

// File: rtl/mc_if.sv
// Instruction-field inputs and datapath control outputs of the control unit.
interface mc_if;
  import mc_pkg::*;

  logic [COND_W-1:0]  Cond;
  logic [OP_W-1:0]    Op;
  logic [FUNCT_W-1:0] Funct;
  logic [REG_W-1:0]   Rd;
  logic [FLAGS_W-1:0] ALUFlags;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       RegWrite;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite
  );
endinterface

// File: rtl/condcheck.sv
// ARM condition-code evaluation against stored {N,Z,C,V} flags.
module condcheck (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v, ge;

  always_comb begin
    {n, z, c, v} = flags;
    ge           = (n == v);
    cond_ex      = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~(c & ~z);
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~z & ge;
      4'b1101: cond_ex = ~(~z & ge);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_mainfsm.sv
// Instruction-sequencing FSM: state register, next state and raw per-state controls.
module mc_mainfsm
  import mc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            i_bit,
  input  logic            l_bit,
  output statetype        state_q,
  output raw_ctrl_t       ctrl_c
);
  statetype state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    ctrl_c  = '0;
    case (state_q)
      S_FETCH: begin
        state_d           = S_DECODE;
        ctrl_c.pc_update  = 1'b1;
        ctrl_c.irwrite    = 1'b1;
        ctrl_c.alusrca    = 1'b1;
        ctrl_c.alusrcb    = SRCB_FOUR;
        ctrl_c.resultsrc  = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl_c.alusrca   = 1'b1;
        ctrl_c.alusrcb   = SRCB_FOUR;
        ctrl_c.resultsrc = RES_ALURESULT;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        state_d        = l_bit ? S_MEMRD : S_MEMWR;
        ctrl_c.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        state_d       = S_MEMWB;
        ctrl_c.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.resultsrc = RES_DATA;
        ctrl_c.regw      = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.adrsrc = 1'b1;
        ctrl_c.memw   = 1'b1;
      end
      S_EXECUTER: begin
        state_d       = S_ALUWB;
        ctrl_c.alu_op = 1'b1;
      end
      S_EXECUTEI: begin
        state_d        = S_ALUWB;
        ctrl_c.alusrcb = SRCB_IMM;
        ctrl_c.alu_op  = 1'b1;
      end
      S_ALUWB: begin
        ctrl_c.resultsrc = RES_ALUOUT;
        ctrl_c.regw      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alusrcb   = SRCB_IMM;
        ctrl_c.resultsrc = RES_ALURESULT;
        ctrl_c.branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: field decode, condition flags and write gating
// around the sequencing FSM.
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.slave  bus
);
  statetype        state;
  raw_ctrl_t       ctrl;
  logic [CMD_W-1:0] cmd;
  logic [1:0]      alu_dp;
  logic [1:0]      flagw_dp;
  logic [1:0]      flag_w;
  logic            nowrite;
  logic            s_bit;
  logic            regw;
  logic            pcs;
  logic            cond_ex_c;
  logic            cond_ex_r_d, cond_ex_r_q;
  logic [FLAGS_W-1:0] flags_d, flags_q;

  mc_mainfsm u_fsm (
    .clk     (clk),
    .rst     (reset),
    .op      (bus.Op),
    .i_bit   (bus.Funct[5]),
    .l_bit   (bus.Funct[0]),
    .state_q (state),
    .ctrl_c  (ctrl)
  );

  condcheck u_cond (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex_c)
  );

  // Data-processing command decode; CMP always updates all four flags.
  always_comb begin
    cmd      = bus.Funct[4:1];
    s_bit    = bus.Funct[0];
    alu_dp   = ALU_ADD;
    nowrite  = 1'b0;
    flagw_dp = 2'b00;
    case (cmd)
      CMD_ADD: begin alu_dp = ALU_ADD; flagw_dp = {s_bit, s_bit}; end
      CMD_SUB: begin alu_dp = ALU_SUB; flagw_dp = {s_bit, s_bit}; end
      CMD_AND: begin alu_dp = ALU_AND; flagw_dp = {s_bit, 1'b0}; end
      CMD_ORR: begin alu_dp = ALU_ORR; flagw_dp = {s_bit, 1'b0}; end
      CMD_CMP: begin alu_dp = ALU_SUB; flagw_dp = 2'b11; nowrite = 1'b1; end
      default: begin alu_dp = ALU_ADD; flagw_dp = 2'b00; nowrite = 1'b1; end
    endcase
  end

  always_comb begin
    flag_w      = ctrl.alu_op ? flagw_dp : 2'b00;
    regw        = ctrl.regw & ~((state == S_ALUWB) & nowrite);
    pcs         = ((bus.Rd == 4'd15) & regw) | ctrl.branch;
    cond_ex_r_d = (state == S_DECODE) ? cond_ex_c : cond_ex_r_q;
    flags_d     = flags_q;
    if (flag_w[1] & cond_ex_r_q) flags_d[3:2] = bus.ALUFlags[3:2];
    if (flag_w[0] & cond_ex_r_q) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= '0;
      cond_ex_r_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

  assign bus.PCWrite    = ctrl.pc_update | (pcs & cond_ex_r_q);
  assign bus.AdrSrc     = ctrl.adrsrc;
  assign bus.MemWrite   = ctrl.memw & cond_ex_r_q;
  assign bus.IRWrite    = ctrl.irwrite;
  assign bus.ResultSrc  = ctrl.resultsrc;
  assign bus.ALUSrcA    = ctrl.alusrca;
  assign bus.ALUSrcB    = ctrl.alusrcb;
  assign bus.ALUControl = ctrl.alu_op ? alu_dp : ALU_ADD;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
  assign bus.RegWrite   = regw & cond_ex_r_q;
endmodule

// File: tb/tb_mc_controller.sv
// Directed vector bench for mc_controller: one vector per clock cycle.
module tb_mc_controller;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] aluf;
  } instr_t;

  typedef struct {
    string      name;
    instr_t     ins;
    logic [11:0] out;
    logic [3:0] flags;
  } vec_t;

  // Output word: PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite
  localparam logic [11:0] FE    = 12'b1_0_0_1_10_1_10_00_0;
  localparam logic [11:0] DE    = 12'b0_0_0_0_10_1_10_00_0;
  localparam logic [11:0] EX_AD = 12'b0_0_0_0_00_0_00_00_0;
  localparam logic [11:0] EX_SB = 12'b0_0_0_0_00_0_00_01_0;
  localparam logic [11:0] EX_OR = 12'b0_0_0_0_00_0_00_11_0;
  localparam logic [11:0] EI_AN = 12'b0_0_0_0_00_0_01_10_0;
  localparam logic [11:0] WB_W  = 12'b0_0_0_0_00_0_00_00_1;
  localparam logic [11:0] WB_N  = 12'b0_0_0_0_00_0_00_00_0;
  localparam logic [11:0] WB_PC = 12'b1_0_0_0_00_0_00_00_1;
  localparam logic [11:0] BR_T  = 12'b1_0_0_0_10_0_01_00_0;
  localparam logic [11:0] BR_F  = 12'b0_0_0_0_10_0_01_00_0;
  localparam logic [11:0] MA    = 12'b0_0_0_0_00_0_01_00_0;
  localparam logic [11:0] MR    = 12'b0_1_0_0_00_0_00_00_0;
  localparam logic [11:0] MWB   = 12'b0_0_0_0_01_0_00_00_1;
  localparam logic [11:0] MW    = 12'b0_1_1_0_00_0_00_00_0;
  localparam logic [11:0] IDLE  = 12'b0_0_0_0_00_0_00_00_0;

  localparam instr_t I_ADD   = {4'hE, 2'b00, 6'b001000, 4'd1,  4'hF};
  localparam instr_t I_SUBS  = {4'hE, 2'b00, 6'b000101, 4'd1,  4'h4};
  localparam instr_t I_BEQ   = {4'h0, 2'b10, 6'b100000, 4'd0,  4'h0};
  localparam instr_t I_ADDS0 = {4'hE, 2'b00, 6'b001001, 4'd2,  4'h0};
  localparam instr_t I_LDR   = {4'hE, 2'b01, 6'b011001, 4'd3,  4'h0};
  localparam instr_t I_STR   = {4'hE, 2'b01, 6'b011000, 4'd3,  4'h0};
  localparam instr_t I_ADDSZ = {4'hE, 2'b00, 6'b001001, 4'd2,  4'h4};
  localparam instr_t I_CMPNE = {4'h1, 2'b00, 6'b010101, 4'd0,  4'h9};
  localparam instr_t I_CMP   = {4'hE, 2'b00, 6'b010100, 4'd0,  4'h2};
  localparam instr_t I_ADDPC = {4'hE, 2'b00, 6'b001000, 4'd15, 4'h0};
  localparam instr_t I_UND   = {4'hE, 2'b11, 6'b000000, 4'd0,  4'h0};
  localparam instr_t I_ANDSI = {4'hE, 2'b00, 6'b100001, 4'd5,  4'hD};
  localparam instr_t I_ORR   = {4'hE, 2'b00, 6'b011000, 4'd4,  4'h0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_mis = 0;
  vec_t tbl[$];

  mc_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, instr_t i, logic [11:0] o, logic [3:0] f);
    vec_t v;
    v.name = n; v.ins = i; v.out = o; v.flags = f;
    return v;
  endfunction

  task automatic apply_check(input vec_t v);
    logic [19:0] got, exp;
    bus.Cond     = v.ins.cond;
    bus.Op       = v.ins.op;
    bus.Funct    = v.ins.funct;
    bus.Rd       = v.ins.rd;
    bus.ALUFlags = v.ins.aluf;
    #1;
    got = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
           bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite,
           bus.ImmSrc, bus.RegSrc, dut.flags_q};
    exp = {v.out, v.ins.op, v.ins.op == 2'b01, v.ins.op == 2'b10, v.flags};
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b required %b", v.name, got, exp);
    end
  endtask

  initial begin
    tbl.push_back(mk("add.fetch",   I_ADD,   FE,    4'h0));
    tbl.push_back(mk("add.decode",  I_ADD,   DE,    4'h0));
    tbl.push_back(mk("add.exec",    I_ADD,   EX_AD, 4'h0));
    tbl.push_back(mk("add.wb",      I_ADD,   WB_W,  4'h0));
    tbl.push_back(mk("subs.fetch",  I_SUBS,  FE,    4'h0));
    tbl.push_back(mk("subs.decode", I_SUBS,  DE,    4'h0));
    tbl.push_back(mk("subs.exec",   I_SUBS,  EX_SB, 4'h0));
    tbl.push_back(mk("subs.wb",     I_SUBS,  WB_W,  4'h4));
    tbl.push_back(mk("beq1.fetch",  I_BEQ,   FE,    4'h4));
    tbl.push_back(mk("beq1.decode", I_BEQ,   DE,    4'h4));
    tbl.push_back(mk("beq1.taken",  I_BEQ,   BR_T,  4'h4));
    tbl.push_back(mk("adds.fetch",  I_ADDS0, FE,    4'h4));
    tbl.push_back(mk("adds.decode", I_ADDS0, DE,    4'h4));
    tbl.push_back(mk("adds.exec",   I_ADDS0, EX_AD, 4'h4));
    tbl.push_back(mk("adds.wb",     I_ADDS0, WB_W,  4'h0));
    tbl.push_back(mk("beq2.fetch",  I_BEQ,   FE,    4'h0));
    tbl.push_back(mk("beq2.decode", I_BEQ,   DE,    4'h0));
    tbl.push_back(mk("beq2.nottkn", I_BEQ,   BR_F,  4'h0));
    tbl.push_back(mk("ldr.fetch",   I_LDR,   FE,    4'h0));
    tbl.push_back(mk("ldr.decode",  I_LDR,   DE,    4'h0));
    tbl.push_back(mk("ldr.memadr",  I_LDR,   MA,    4'h0));
    tbl.push_back(mk("ldr.memrd",   I_LDR,   MR,    4'h0));
    tbl.push_back(mk("ldr.memwb",   I_LDR,   MWB,   4'h0));
    tbl.push_back(mk("str.fetch",   I_STR,   FE,    4'h0));
    tbl.push_back(mk("str.decode",  I_STR,   DE,    4'h0));
    tbl.push_back(mk("str.memadr",  I_STR,   MA,    4'h0));
    tbl.push_back(mk("str.memwr",   I_STR,   MW,    4'h0));
    tbl.push_back(mk("addsz.fetch", I_ADDSZ, FE,    4'h0));
    tbl.push_back(mk("addsz.dec",   I_ADDSZ, DE,    4'h0));
    tbl.push_back(mk("addsz.exec",  I_ADDSZ, EX_AD, 4'h0));
    tbl.push_back(mk("addsz.wb",    I_ADDSZ, WB_W,  4'h4));
    tbl.push_back(mk("cmpne.fetch", I_CMPNE, FE,    4'h4));
    tbl.push_back(mk("cmpne.dec",   I_CMPNE, DE,    4'h4));
    tbl.push_back(mk("cmpne.exec",  I_CMPNE, EX_SB, 4'h4));
    tbl.push_back(mk("cmpne.wb",    I_CMPNE, WB_N,  4'h4));
    tbl.push_back(mk("cmp.fetch",   I_CMP,   FE,    4'h4));
    tbl.push_back(mk("cmp.decode",  I_CMP,   DE,    4'h4));
    tbl.push_back(mk("cmp.exec",    I_CMP,   EX_SB, 4'h4));
    tbl.push_back(mk("cmp.wb",      I_CMP,   WB_N,  4'h2));
    tbl.push_back(mk("addpc.fetch", I_ADDPC, FE,    4'h2));
    tbl.push_back(mk("addpc.dec",   I_ADDPC, DE,    4'h2));
    tbl.push_back(mk("addpc.exec",  I_ADDPC, EX_AD, 4'h2));
    tbl.push_back(mk("addpc.wb",    I_ADDPC, WB_PC, 4'h2));
    tbl.push_back(mk("und.fetch",   I_UND,   FE,    4'h2));
    tbl.push_back(mk("und.decode",  I_UND,   DE,    4'h2));
    tbl.push_back(mk("und.unknown", I_UND,   IDLE,  4'h2));
    tbl.push_back(mk("andsi.fetch", I_ANDSI, FE,    4'h2));
    tbl.push_back(mk("andsi.dec",   I_ANDSI, DE,    4'h2));
    tbl.push_back(mk("andsi.exec",  I_ANDSI, EI_AN, 4'h2));
    tbl.push_back(mk("andsi.wb",    I_ANDSI, WB_W,  4'hE));
    tbl.push_back(mk("orr.fetch",   I_ORR,   FE,    4'hE));
    tbl.push_back(mk("orr.decode",  I_ORR,   DE,    4'hE));
    tbl.push_back(mk("orr.exec",    I_ORR,   EX_OR, 4'hE));
    tbl.push_back(mk("orr.wb",      I_ORR,   WB_W,  4'hE));

    // Power-on reset before any clock edge
    #1 reset = 1'b1;
    apply_check(mk("reset.init", I_ADD, FE, 4'h0));
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      if (i > 0) @(negedge clk);
      apply_check(tbl[i]);
    end

    // Reset asserted in the middle of an LDR's MEMRD cycle
    @(negedge clk); apply_check(mk("ldr2.fetch",  I_LDR, FE, 4'hE));
    @(negedge clk); apply_check(mk("ldr2.decode", I_LDR, DE, 4'hE));
    @(negedge clk); apply_check(mk("ldr2.memadr", I_LDR, MA, 4'hE));
    @(negedge clk); apply_check(mk("ldr2.memrd",  I_LDR, MR, 4'hE));
    reset = 1'b1;
    apply_check(mk("ldr2.reset", I_LDR, FE, 4'h0));
    n_vec++;
    if (dut.cond_ex_r_q !== 1'b0) begin
      n_mis++;
      $display("FAIL ldr2.condexr: got %b required 0", dut.cond_ex_r_q);
    end
    @(negedge clk);
    reset = 1'b0;
    apply_check(mk("post.fetch",  I_LDR, FE, 4'h0));
    @(negedge clk); apply_check(mk("post.decode", I_LDR, DE, 4'h0));
    @(negedge clk); apply_check(mk("post.memadr", I_LDR, MA, 4'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
